// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: datapath widths,
// the ALU_8bit opcode encoding and the sequencer state encoding.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] ALU_ADD = 3'd0;  // c = carry out
    localparam logic [SEL_W-1:0] ALU_SUB = 3'd1;  // c = borrow (a < b)
    localparam logic [SEL_W-1:0] ALU_AND = 3'd2;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'd3;
    localparam logic [SEL_W-1:0] ALU_XOR = 3'd4;
    localparam logic [SEL_W-1:0] ALU_NOT = 3'd5;  // res = ~a
    localparam logic [SEL_W-1:0] ALU_SHL = 3'd6;  // c = bit shifted out (a[7])
    localparam logic [SEL_W-1:0] ALU_SHR = 3'd7;  // c = bit shifted out (a[0])

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ALU_8bit.sv
// Combinational 8-bit ALU; zero latency, no flow control.
// Logic ops clear c; arithmetic and shifts report carry/borrow/shifted-out bit.
module ALU_8bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [ALU_W-1:0] res,
    output logic             c
);

    always_comb begin
        res = '0;
        c   = 1'b0;
        case (sel)
            ALU_ADD: {c, res} = {1'b0, a} + {1'b0, b};
            ALU_SUB: {c, res} = {1'b0, a} - {1'b0, b};
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_NOT: res = ~a;
            ALU_SHL: {c, res} = {a, 1'b0};
            ALU_SHR: {res, c} = {1'b0, a};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU_8bit among N_REQ requesters: grant, execute, respond (3 cycles min).
// No new grant until the tagged response is accepted; rsp_* frozen while rsp_ready is low.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [ALU_W*N_REQ-1:0] req_a,
    input  logic [ALU_W*N_REQ-1:0] req_b,
    input  logic [SEL_W*N_REQ-1:0] req_sel,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [ALU_W-1:0]       rsp_res,
    output logic                   rsp_c,
    input  logic                   rsp_ready,
    output logic                   busy
);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ALU_W-1:0] op_a;
    logic [ALU_W-1:0] op_b;
    logic [SEL_W-1:0] op_sel;
    logic [ID_W-1:0]  op_id;

    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic [ALU_W-1:0] alu_res;
    logic             alu_c;

    // First valid requester at or after p, wrapping past N_REQ-1 back to 0.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] pick;
        logic            found;
        logic [ID_W:0]   j;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = {1'b0, p} + (ID_W+1)'(i);
            if (j >= (ID_W+1)'(N_REQ))
                j = j - (ID_W+1)'(N_REQ);
            if (!found && vld[j[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = j[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    assign gnt_id  = rr_pick(req_valid, ptr);
    assign gnt_any = (state == IDLE) && (|req_valid) && !rst;

    always_comb begin
        req_ready = '0;
        if (gnt_any)
            req_ready[gnt_id] = 1'b1;
    end

    assign busy = (state != IDLE);

    ALU_8bit u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .res (alu_res),
        .c   (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_c     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a   <= req_a[gnt_id*ALU_W +: ALU_W];
                        op_b   <= req_b[gnt_id*ALU_W +: ALU_W];
                        op_sel <= req_sel[gnt_id*SEL_W +: SEL_W];
                        op_id  <= gnt_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res   <= alu_res;
                    rsp_c     <= alu_c;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (op_id == ID_W'(N_REQ-1)) ? '0 : op_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
